// File: rtl/jtframe_pll_supervisor.sv
// jtframe_pll_supervisor
//
// Consumer-side supervisor for the clock/reset generator outputs. It takes
// the raw (asynchronous) PLL lock flag and a game reset request, and produces
// a clean, sequenced core reset in the local clock domain. Lock glitches are
// filtered, reset is held for a programmable time once lock is stable, and
// loss-of-lock events are reported to the OSD/debug logic. One instance sits
// in each clock domain that needs a lock-qualified reset.
//
// Parameters:
//   SYNC   - synchroniser depth on pll_locked (>= 2)
//   FILTER - cycles the synchronised lock must stay high before hold (>= 1)
//   HOLD   - cycles reset stays asserted after the filter passes (>= 1)
//   CNTW   - width of the loss-of-lock event counter
//
// Ports:
//   clk        in   supervised clock domain
//   rst        in   synchronous active-high reset, overrides everything
//   pll_locked in   raw lock flag, asynchronous to clk
//   soft_rst   in   game/user reset request pulse, synchronous to clk
//   lost_clr   in   clears the sticky lost flag
//   rst_out    out  sequenced core reset, active high
//   ready      out  high while the core is running
//   lost       out  sticky flag: lock dropped after the filter had started
//   loss_cnt   out  saturating count of loss-of-lock events
//   state_dbg  out  current state: WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3

module jtframe_pll_supervisor #(
    parameter int SYNC   = 2,
    parameter int FILTER = 16,
    parameter int HOLD   = 1024,
    parameter int CNTW   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pll_locked,
    input  logic            soft_rst,
    input  logic            lost_clr,
    output logic            rst_out,
    output logic            ready,
    output logic            lost,
    output logic [CNTW-1:0] loss_cnt,
    output logic [1:0]      state_dbg
);

    // One counter is shared by FILTER and HOLD, so it only needs to reach
    // the larger of the two terminal values.
    localparam int MAXC = (FILTER > HOLD) ? FILTER : HOLD;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] FILT_LAST = CW'(FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_FILTER    = 2'd1,
        ST_HOLD      = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SYNC-1:0] sync_q;
    logic            lk_s;
    logic            loss_ev;

    logic            rst_out_q, rst_out_d;
    logic            ready_q, ready_d;
    logic            lost_q, lost_d;
    logic [CNTW-1:0] loss_cnt_q, loss_cnt_d;

    // ------------------------------------------------------------------
    // Lock synchroniser: only the last stage is used downstream.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], pll_locked};
        end
    end

    assign lk_s = sync_q[SYNC-1];

    // ------------------------------------------------------------------
    // State register (also registers the outputs so they move on the
    // same edge as the state).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT_LOCK;
            cnt_q      <= '0;
            rst_out_q  <= 1'b1;
            ready_q    <= 1'b0;
            lost_q     <= 1'b0;
            loss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rst_out_q  <= rst_out_d;
            ready_q    <= ready_d;
            lost_q     <= lost_d;
            loss_cnt_q <= loss_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Priority: lock loss > soft reset > counter.
    // The counter is cleared on every state entry.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_ev = 1'b0;

        case (state_q)
            ST_WAIT_LOCK: begin
                // A lock drop here is not a loss event: nothing had started.
                if (lk_s) begin
                    state_d = ST_FILTER;
                    cnt_d   = '0;
                end
            end

            ST_FILTER: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    loss_ev = 1'b1;
                end else if (cnt_q == FILT_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_HOLD: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    loss_ev = 1'b1;
                end else if (soft_rst) begin
                    // A new request restarts the full hold time.
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ST_RUN: begin
                if (!lk_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    loss_ev = 1'b1;
                end else if (soft_rst) begin
                    // Lock is known good: skip the filter, go straight to hold.
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: computed from the next state so the registered
    // outputs line up with the registered state.
    // ------------------------------------------------------------------
    always_comb begin
        rst_out_d  = (state_d != ST_RUN);
        ready_d    = (state_d == ST_RUN);

        // A coincident loss event wins over the clear.
        lost_d     = lost_q;
        if (loss_ev) begin
            lost_d = 1'b1;
        end else if (lost_clr) begin
            lost_d = 1'b0;
        end

        loss_cnt_d = loss_cnt_q;
        if (loss_ev && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + 1'b1;
        end
    end

    assign rst_out   = rst_out_q;
    assign ready     = ready_q;
    assign lost      = lost_q;
    assign loss_cnt  = loss_cnt_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_jtframe_pll_supervisor.sv
// Testbench for jtframe_pll_supervisor (SYNC=2, FILTER=4, HOLD=8, CNTW=2).
// The reference model tracks "lock age" (edges of continuous synchronised
// lock since the sequence restarted) and the age at which the latest hold
// began; the phase is derived from those two numbers.

module tb_jtframe_pll_supervisor;

    localparam int SYNC   = 2;
    localparam int FILTER = 4;
    localparam int HOLD   = 8;
    localparam int CNTW   = 2;
    localparam int CMAX   = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            pll_locked;
    logic            soft_rst;
    logic            lost_clr;
    logic            rst_out;
    logic            ready;
    logic            lost;
    logic [CNTW-1:0] loss_cnt;
    logic [1:0]      state_dbg;

    always #5 clk = ~clk;

    jtframe_pll_supervisor #(
        .SYNC   (SYNC),
        .FILTER (FILTER),
        .HOLD   (HOLD),
        .CNTW   (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pll_locked (pll_locked),
        .soft_rst   (soft_rst),
        .lost_clr   (lost_clr),
        .rst_out    (rst_out),
        .ready      (ready),
        .lost       (lost),
        .loss_cnt   (loss_cnt),
        .state_dbg  (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    int m_age;        // edges of continuous lk_s=1 since the sequence restarted
    int m_hold_from;  // age at which the current hold period began
    bit m_lost;
    int m_cnt;
    bit m_samp[$];    // the last SYNC samples of pll_locked, oldest first

    function automatic int m_phase();
        if (m_age == 0)                    return 0;
        if (m_age <= FILTER)               return 1;
        if (m_age - m_hold_from < HOLD)    return 2;
        return 3;
    endfunction

    function automatic void model_edge(input bit r, input bit l, input bit s, input bit c);
        bit lks;
        bit loss;
        if (r) begin
            m_age = 0; m_hold_from = FILTER + 1; m_lost = 0; m_cnt = 0;
            m_samp.delete();
            for (int i = 0; i < SYNC; i++) m_samp.push_back(1'b0);
            return;
        end
        lks = m_samp[0];
        void'(m_samp.pop_front());
        m_samp.push_back(l);
        loss = 0;
        if (!lks) begin
            loss = (m_age > 0);
            m_age = 0;
            m_hold_from = FILTER + 1;
        end else begin
            // soft reset only matters once the filter has passed
            if (s && m_age >= FILTER + 1) m_hold_from = m_age + 1;
            m_age++;
        end
        if (loss) begin
            m_lost = 1;
            if (m_cnt < CMAX) m_cnt++;
        end else if (c) begin
            m_lost = 0;
        end
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic chk_model();
        int ph;
        ph = m_phase();
        chk("model_rst_out",  rst_out,   (ph != 3));
        chk("model_ready",    ready,     (ph == 3));
        chk("model_state",    state_dbg, ph);
        chk("model_lost",     lost,      m_lost);
        chk("model_loss_cnt", loss_cnt,  m_cnt);
    endtask

    task automatic step(input logic r, input logic l, input logic s, input logic c);
        rst = r; pll_locked = l; soft_rst = s; lost_clr = c;
        @(posedge clk);
        model_edge(r, l, s, c);
        #1;
        chk_model();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic            r, l, s, c;
        logic            e_rst, e_rdy;
        logic [1:0]      e_st;
        logic            e_lost;
        logic [CNTW-1:0] e_cnt;
    } vec_t;

    vec_t vecs[25];

    initial begin
        int n;
        logic lk_cur;

        rst = 1'b1; pll_locked = 1'b0; soft_rst = 1'b0; lost_clr = 1'b0;

        // Clean lock: lock sampled first at edge 1, RUN after edge 15;
        // soft reset at edge 16 holds for 8 edges without refiltering.
        for (int i = 0; i < 25; i++) begin
            vecs[i].r = (i == 0);
            vecs[i].l = (i != 0);
            vecs[i].s = (i == 16);
            vecs[i].c = 1'b0;
            if (i <= 2)       vecs[i].e_st = 2'd0;
            else if (i <= 6)  vecs[i].e_st = 2'd1;
            else if (i <= 14) vecs[i].e_st = 2'd2;
            else if (i == 15) vecs[i].e_st = 2'd3;
            else if (i <= 23) vecs[i].e_st = 2'd2;
            else              vecs[i].e_st = 2'd3;
            vecs[i].e_rst  = (vecs[i].e_st != 2'd3);
            vecs[i].e_rdy  = (vecs[i].e_st == 2'd3);
            vecs[i].e_lost = 1'b0;
            vecs[i].e_cnt  = '0;
        end
        for (int i = 0; i < 25; i++) begin
            step(vecs[i].r, vecs[i].l, vecs[i].s, vecs[i].c);
            chk("tbl_rst_out",  rst_out,   vecs[i].e_rst);
            chk("tbl_ready",    ready,     vecs[i].e_rdy);
            chk("tbl_state",    state_dbg, vecs[i].e_st);
            chk("tbl_lost",     lost,      vecs[i].e_lost);
            chk("tbl_loss_cnt", loss_cnt,  vecs[i].e_cnt);
        end

        // Filter glitch: low for 3 samples starting 2 cycles into FILTER.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        chk("glitch_in_filter", state_dbg, 2'd1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        chk("glitch_state", state_dbg, 2'd0);
        chk("glitch_lost",  lost,      1'b1);
        chk("glitch_cnt",   loss_cnt,  1);
        n = 0;
        do begin step(0, 1, 0, 0); n++; end while (rst_out !== 1'b0 && n < 40);
        chk("glitch_relock_latency", n, 15);

        // Loss in RUN: one-cycle drop.
        step(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
        chk("run_ready", ready, 1'b1);
        step(0, 0, 0, 0);
        n = 1;
        while (rst_out !== 1'b1 && n < 10) begin step(0, 1, 0, 0); n++; end
        chk("run_loss_reassert_edges", n, SYNC + 1);
        chk("run_loss_state", state_dbg, 2'd0);
        chk("run_loss_cnt",   loss_cnt,  1);
        while (rst_out !== 1'b0 && n < 40) begin step(0, 1, 0, 0); n++; end
        chk("run_loss_relock_edges", n, 16);

        // Soft reset in RUN, then a second pulse mid-HOLD.
        step(0, 1, 1, 0);
        chk("soft_rst_out", rst_out,   1'b1);
        chk("soft_state",   state_dbg, 2'd2);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        n = 0;
        do begin step(0, 1, 0, 0); n++; end while (rst_out !== 1'b0 && n < 40);
        chk("soft_extend_edges", n, HOLD);

        // Saturation and clear.
        step(1, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
            for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        end
        chk("sat_cnt",  loss_cnt, CMAX);
        chk("sat_lost", lost,     1'b1);
        step(0, 0, 0, 1);
        chk("clr_lost", lost,     1'b0);
        chk("clr_cnt",  loss_cnt, CMAX);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);   // loss event lands on this edge
        chk("clr_vs_loss_lost", lost, 1'b1);

        // Reset mid-HOLD at counter 5.
        n = 0;
        while (!(m_phase() == 2 && m_age - m_hold_from == 5) && n < 40) begin
            step(0, 1, 0, 0); n++;
        end
        chk("midhold_reached", state_dbg, 2'd2);
        step(1, 1, 0, 0);
        chk("midhold_rst_out", rst_out,   1'b1);
        chk("midhold_ready",   ready,     1'b0);
        chk("midhold_state",   state_dbg, 2'd0);
        chk("midhold_cnt",     loss_cnt,  0);
        n = 0;
        do begin step(0, 1, 0, 0); n++; end while (rst_out !== 1'b0 && n < 40);
        chk("midhold_release_edges", n, 15);
        step(1, 1, 1, 1);
        chk("midrun_ready", ready,     1'b0);
        chk("midrun_state", state_dbg, 2'd0);

        // Randomised traffic against the model.
        lk_cur = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (lk_cur) begin
                if ($urandom_range(0, 59) == 0) lk_cur = 1'b0;
            end else begin
                if ($urandom_range(0, 3) == 0) lk_cur = 1'b1;
            end
            step(($urandom_range(0, 299) == 0), lk_cur,
                 ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtframe_pll_supervisor.md
Name: jtframe_pll_supervisor

Overview:
- Consumer-side supervisor for the clock/reset generator outputs.
- Takes the raw, asynchronous PLL lock flag and the game reset request, and produces a clean, sequenced core reset in its own clock domain.
- Filters lock glitches, holds reset for a programmable time after lock is stable, and reports loss-of-lock events to the OSD/debug logic.
- One instance sits in each clock domain that needs lock-qualified reset.

Parameters:
- SYNC, 2, number of synchroniser flops on pll_locked (≥2)
- FILTER, 16, consecutive cycles synchronised lock must stay high before reset hold starts (≥1)
- HOLD, 1024, cycles reset stays asserted after filter passes (≥1)
- CNTW, 8, width of loss-of-lock event counter

Ports:
- clk, input, 1, supervised clock domain
- rst, input, 1, synchronous active-high reset
- pll_locked, input, 1, raw lock flag; asynchronous to clk
- soft_rst, input, 1, game/user reset request pulse, synchronous to clk
- lost_clr, input, 1, clears the lost flag (synchronous)
- rst_out, output, 1, sequenced core reset, active high
- ready, output, 1, high when the core is running (state RUN)
- lost, output, 1, sticky flag: lock dropped after the filter had started
- loss_cnt, output, CNTW, saturating count of loss-of-lock events
- state_dbg, output, 2, current state encoding: WAIT_LOCK=0, FILTER=1, HOLD=2, RUN=3

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high; it overrides all other inputs.
- Reset values:
  - state=WAIT_LOCK, counter=0
  - synchroniser flops=0
  - rst_out=1, ready=0, lost=0, loss_cnt=0
- Synchronisation: pll_locked passes through a SYNC-flop chain; lk_s is the last stage. Only lk_s is used downstream.
- Single shared counter, wide enough for max(FILTER,HOLD)-1. It is cleared on every state entry.
- State WAIT_LOCK:
  - rst_out=1.
  - lk_s=1 → FILTER.
- State FILTER:
  - rst_out=1.
  - lk_s=0 → WAIT_LOCK; loss event.
  - Else the counter increments; when counter==FILTER-1 → HOLD.
- State HOLD:
  - rst_out=1.
  - lk_s=0 → WAIT_LOCK; loss event.
  - soft_rst=1 → counter reloads to 0 and the state stays HOLD.
  - Else when counter==HOLD-1 → RUN.
- State RUN:
  - rst_out=0, ready=1.
  - lk_s=0 → WAIT_LOCK; loss event.
  - soft_rst=1 with lk_s=1 → HOLD, counter=0. The lock filter is not re-run.
- Priority each cycle: rst > lk_s=0 > soft_rst > counter progress.
- Loss event:
  - lost is set the cycle after the transition.
  - loss_cnt increments, saturating at 2^CNTW-1 with no wrap.
  - A lk_s drop in WAIT_LOCK is not a loss event.
- lost_clr=1 clears lost. If lost_clr coincides with a loss event, set wins. lost_clr does not affect loss_cnt.
- rst_out and ready are registered and derived from the registered state: both change on the same edge as the state.
- Latency: rst_out deasserts exactly SYNC+1+FILTER+HOLD rising edges after the first edge at which pll_locked is sampled high, provided lock stays high and soft_rst stays low.
- Re-assertion:
  - rst_out re-asserts on edge SYNC+1 after pll_locked is first sampled low while in RUN.
  - rst_out re-asserts one edge after soft_rst is sampled high while in RUN.
- Lock glitches shorter than one clk period may or may not be seen. Any glitch that reaches lk_s in FILTER, HOLD or RUN must restart the full sequence.
- rst asserted mid-HOLD or mid-RUN returns every output to its reset value on the next edge. The sequence restarts from WAIT_LOCK.
- Inputs soft_rst and lost_clr are ignored while rst=1.

Test Plan:
- Clean lock (SYNC=2, FILTER=4, HOLD=8): release rst, pll_locked=1 at edge 0 → rst_out=1 through edge 14, rst_out=0 and ready=1 after edge 15, loss_cnt=0, lost=0.
- Filter glitch: pll_locked low for 3 cycles starting 2 cycles into FILTER → return to WAIT_LOCK, lost=1, loss_cnt=1. A full 15-cycle sequence is required after lock is restored.
- Loss in RUN: drop pll_locked for 1 cycle while ready=1 → rst_out=1 and state_dbg=0 within 3 edges, loss_cnt increments to 1. Relock releases rst_out 15 edges later.
- Soft reset: soft_rst pulse in RUN → rst_out=1 next edge, state_dbg=2, released 8 edges later with no refilter. A second pulse mid-HOLD extends the hold by a full 8 cycles.
- Saturation and clear (CNTW=2): 5 loss events → loss_cnt=3. lost_clr alone → lost=0, loss_cnt=3. lost_clr coinciding with a loss event → lost=1.
- Reset mid-operation: assert rst during HOLD counter=5 → next edge rst_out=1, ready=0, state_dbg=0, loss_cnt=0. Deasserting rst with lock held high releases rst_out after 15 edges.
